lab4_ctrl_fsm: RTL and testbench

- Multicycle control sequencer that sits after the lab4 instruction decoder (ins_type / data_ins_type) and drives datapath strobes.
- Accepts one instruction at a time over a valid/ready handshake and walks it through DECODE/EXEC/MEM/WB.
- Handles multi-cycle multiply, memory wait states with timeout, undefined-instruction trap and condition-failed squash.
- Keeps a retired-instruction counter for bring-up.

---
 rtl/lab4_ctrl_fsm.sv | 103 ++++++++++
 tb/tb_lab4_ctrl_fsm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/lab4_ctrl_fsm.sv
// lab4_ctrl_fsm: multicycle control sequencer walking one decoded instruction at a time
// through DECODE/EXEC/MEM/WB and driving Moore datapath strobes.
module lab4_ctrl_fsm #(
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instruction,
  input  logic [1:0]       ins_type,
  input  logic [2:0]       data_ins_type,
  input  logic             cond_pass,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             alu_start,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             link_write,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             retire,
  output logic             undef_trap,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_count
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;
  localparam int CMAX = (MUL_CYCLES > MEM_TIMEOUT) ? MUL_CYCLES : MEM_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       type_q;
  logic             mul_q, load_q, link_q, cond_q;
  logic [CNT_W-1:0] retired_count_q;
  logic             accept, exec_done, mem_expired, wr_ok;
  logic             unused_bits;
  assign unused_bits = ^{instruction[31:25], instruction[23:21], instruction[19:0], data_ins_type[1:0]};
  assign instr_ready = (state_q == IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign exec_done   = cnt_q == (mul_q ? CW'(MUL_CYCLES - 1) : '0);
  assign mem_expired = cnt_q == CW'(MEM_TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? DECODE : IDLE;
      DECODE:  state_d = (type_q == 2'b11) ? TRAP : (cond_q ? EXEC : WB);
      EXEC:    state_d = !exec_done ? EXEC : ((type_q == 2'b01) ? MEM : WB);
      MEM:     state_d = mem_ready ? WB : (mem_expired ? TRAP : MEM);
      default: state_d = IDLE;
    endcase
    // one counter serves both EXEC length and MEM wait; it restarts on every state entry
    cnt_d = (state_d == state_q && (state_q == EXEC || state_q == MEM)) ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      type_q          <= '0;
      mul_q           <= 1'b0;
      load_q          <= 1'b0;
      link_q          <= 1'b0;
      cond_q          <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        type_q <= ins_type;
        mul_q  <= data_ins_type[2] && (ins_type == 2'b00);
        load_q <= instruction[20];
        link_q <= instruction[24];
        cond_q <= cond_pass;
      end
      if (retire) retired_count_q <= retired_count_q + CNT_W'(1);
    end
  end
  // a squashed instruction reaches WB with cond_q low and only advances the PC
  assign wr_ok         = (state_q == WB) && cond_q;
  assign ir_write      = accept;
  assign alu_start     = (state_q == EXEC) && (cnt_q == '0);
  assign mem_read      = (state_q == MEM) && load_q;
  assign mem_write     = (state_q == MEM) && !load_q;
  assign reg_write     = wr_ok && ((type_q == 2'b00) || ((type_q == 2'b01) && load_q));
  assign link_write    = wr_ok && (type_q == 2'b10) && link_q;
  assign pc_write      = state_q == WB;
  assign pc_branch     = wr_ok && (type_q == 2'b10);
  assign retire        = state_q == WB;
  assign undef_trap    = (state_q == TRAP) && (type_q == 2'b11);
  assign bus_err       = (state_q == TRAP) && (type_q != 2'b11);
  assign state         = state_q;
  assign retired_count = retired_count_q;
endmodule

// File: tb/tb_lab4_ctrl_fsm.sv
// tb_lab4_ctrl_fsm: directed cycle-by-cycle checks of state and strobes with hand-computed expectations.
module tb_lab4_ctrl_fsm;
  localparam int CW = 5;
  localparam logic [11:0] RDY = 12'h800, IRW = 12'h400, ALU = 12'h200, MRD = 12'h100,
                          MWR = 12'h080, RGW = 12'h040, LNK = 12'h020, PCW = 12'h010,
                          PCB = 12'h008, RET = 12'h004, UND = 12'h002, BER = 12'h001;
  logic clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, cond_pass = 1'b0, mem_ready = 1'b0;
  logic [31:0] instruction = '0;
  logic [1:0] ins_type = '0;
  logic [2:0] data_ins_type = '0;
  logic instr_ready, ir_write, alu_start, mem_read, mem_write, reg_write, link_write;
  logic pc_write, pc_branch, retire, undef_trap, bus_err;
  logic [2:0] state;
  logic [CW-1:0] retired_count;
  logic [11:0] strb;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  lab4_ctrl_fsm #(.MUL_CYCLES(4), .MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .ins_type(ins_type), .data_ins_type(data_ins_type),
    .cond_pass(cond_pass), .mem_ready(mem_ready), .ir_write(ir_write), .alu_start(alu_start),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .link_write(link_write),
    .pc_write(pc_write), .pc_branch(pc_branch), .retire(retire), .undef_trap(undef_trap),
    .bus_err(bus_err), .state(state), .retired_count(retired_count)
  );
  assign strb = {instr_ready, ir_write, alu_start, mem_read, mem_write, reg_write,
                 link_write, pc_write, pc_branch, retire, undef_trap, bus_err};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask
  task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] sb);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".strobes"}, 32'(strb), 32'(sb));
    nxt();
  endtask
  task automatic issue(input logic [1:0] t, input logic [2:0] d, input logic b20, input logic b24, input logic c);
    instruction = '0;
    instruction[20] = b20;
    instruction[24] = b24;
    ins_type = t;
    data_ins_type = d;
    cond_pass = c;
    instr_valid = 1'b1;
    #1;
    cyc("accept", 3'd0, RDY | IRW);
    instr_valid = 1'b0;
    #1;
  endtask
  initial begin
    nxt();
    cyc("reset", 3'd0, 12'h000);
    reset = 1'b0;
    #1;
    check("reset.idle", 32'(strb), 32'(RDY));
    check("reset.count", 32'(retired_count), 0);
    issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc("dp.dec", 3'd1, 12'h000);
    cyc("dp.exec", 3'd2, ALU);
    cyc("dp.wb", 3'd4, RGW | PCW | RET);
    cyc("dp.idle", 3'd0, RDY);
    check("dp.count", 32'(retired_count), 1);
    issue(2'b00, 3'b100, 1'b0, 1'b0, 1'b1);
    cyc("mul.dec", 3'd1, 12'h000);
    cyc("mul.exec0", 3'd2, ALU);
    for (int i = 0; i < 3; i++) cyc("mul.exec", 3'd2, 12'h000);
    cyc("mul.wb", 3'd4, RGW | PCW | RET);
    check("mul.count", 32'(retired_count), 2);
    issue(2'b01, 3'b100, 1'b1, 1'b0, 1'b1);
    cyc("ld.dec", 3'd1, 12'h000);
    cyc("ld.exec", 3'd2, ALU);
    for (int i = 0; i < 3; i++) cyc("ld.wait", 3'd3, MRD);
    mem_ready = 1'b1;
    cyc("ld.mem", 3'd3, MRD);
    mem_ready = 1'b0;
    cyc("ld.wb", 3'd4, RGW | PCW | RET);
    check("ld.count", 32'(retired_count), 3);
    issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc("st.dec", 3'd1, 12'h000);
    cyc("st.exec", 3'd2, ALU);
    mem_ready = 1'b1;
    cyc("st.mem", 3'd3, MWR);
    mem_ready = 1'b0;
    cyc("st.wb", 3'd4, PCW | RET);
    check("st.count", 32'(retired_count), 4);
    issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc("to.dec", 3'd1, 12'h000);
    cyc("to.exec", 3'd2, ALU);
    for (int i = 0; i < 15; i++) cyc("to.mem", 3'd3, MWR);
    cyc("to.trap", 3'd5, BER);
    cyc("to.idle", 3'd0, RDY);
    check("to.count", 32'(retired_count), 4);
    issue(2'b01, 3'b000, 1'b1, 1'b0, 1'b1);
    cyc("edge.dec", 3'd1, 12'h000);
    cyc("edge.exec", 3'd2, ALU);
    for (int i = 0; i < 14; i++) cyc("edge.mem", 3'd3, MRD);
    mem_ready = 1'b1;
    cyc("edge.last", 3'd3, MRD);
    mem_ready = 1'b0;
    cyc("edge.wb", 3'd4, RGW | PCW | RET);
    check("edge.count", 32'(retired_count), 5);
    issue(2'b11, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc("und.dec", 3'd1, 12'h000);
    cyc("und.trap", 3'd5, UND);
    cyc("und.idle", 3'd0, RDY);
    check("und.count", 32'(retired_count), 5);
    issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1);
    cyc("bl.dec", 3'd1, 12'h000);
    cyc("bl.exec", 3'd2, ALU);
    cyc("bl.wb", 3'd4, LNK | PCW | PCB | RET);
    issue(2'b10, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc("b.dec", 3'd1, 12'h000);
    cyc("b.exec", 3'd2, ALU);
    cyc("b.wb", 3'd4, PCW | PCB | RET);
    check("b.count", 32'(retired_count), 7);
    issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc("sq.dec", 3'd1, 12'h000);
    cyc("sq.wb", 3'd4, PCW | RET);
    check("sq.count", 32'(retired_count), 8);
    issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    instr_valid = 1'b1;
    #1;
    cyc("busy.dec", 3'd1, 12'h000);
    cyc("busy.exec", 3'd2, ALU);
    instr_valid = 1'b0;
    cyc("busy.wb", 3'd4, RGW | PCW | RET);
    check("busy.count", 32'(retired_count), 9);
    issue(2'b01, 3'b000, 1'b1, 1'b0, 1'b1);
    cyc("rst.dec", 3'd1, 12'h000);
    cyc("rst.exec", 3'd2, ALU);
    cyc("rst.mem", 3'd3, MRD);
    reset = 1'b1;
    #1;
    cyc("rst.hold", 3'd3, MRD);
    cyc("rst.clr", 3'd0, 12'h000);
    check("rst.count", 32'(retired_count), 0);
    reset = 1'b0;
    #1;
    check("rst.ready", 32'(strb), 32'(RDY));
    for (int i = 1; i <= 33; i++) begin
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
      nxt();
      nxt();
      if (i == 31) check("wrap.max", 32'(retired_count), 31);
    end
    check("wrap.count", 32'(retired_count), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
